// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB UART with TX/RX FIFOs, programmable baud divisor, optional parity,
// sticky W1C error status and a registered level interrupt.
module apb_uart_fifo_q #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full fifo still lands
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

module apb_uart_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  logic [4:0] ctrl;
  logic [DIV_WIDTH-1:0] baud, div_eff;
  logic [2:0] err, err_set, err_clr;
  logic acc, wr_en, a_ctrl, a_baud, a_tx, a_rx, a_stat, mapped;
  logic tx_push, tx_full, tx_empty, rx_pop, rx_push, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout, status;
  logic unused_bits;
  assign acc = PSEL & PENABLE;
  assign wr_en = acc & PWRITE;
  assign a_ctrl = PADDR == 8'h00;
  assign a_baud = PADDR == 8'h04;
  assign a_tx = PADDR == 8'h08;
  assign a_rx = PADDR == 8'h0C;
  assign a_stat = PADDR == 8'h10;
  assign mapped = a_ctrl | a_baud | a_tx | a_rx | a_stat;
  assign PREADY = 1'b1;
  assign PSLVERR = acc & (~mapped | (PWRITE & a_tx & tx_full));
  assign tx_push = wr_en & a_tx & ~tx_full;
  assign rx_pop = acc & ~PWRITE & a_rx;
  assign div_eff = baud == '0 ? ONE : baud;
  assign unused_bits = ^PWDATA[31:8];

  state_t tx_st, tx_nx, rx_st, rx_nx;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_div, rx_cnt, rx_div, rx_lim;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh;
  logic tx_par, tx_pe, tx_tick, tx_load;
  logic rx_m, rx_s, rx_q, rx_pe, rx_odd, rx_tick;

  assign status = {tx_st != IDLE, err, rx_empty, rx_full, tx_empty, tx_full};
  assign PRDATA = !PSEL ? 32'h0 :
                  a_ctrl ? {27'h0, ctrl} :
                  a_baud ? 32'(baud) :
                  a_rx ? {24'h0, rx_empty ? 8'h00 : rx_dout} :
                  a_stat ? {24'h0, status} : 32'h0;

  apb_uart_fifo_q #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_load), .din(PWDATA[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty));
  apb_uart_fifo_q #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty));

  // a new frame may start straight out of STOP, giving back-to-back frames
  assign tx_tick = tx_cnt == tx_div - ONE;
  assign tx_load = ctrl[0] & ~tx_empty & (tx_st == IDLE | (tx_st == STOP & tx_tick));
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      START:   if (tx_tick) tx_nx = DATA;
      DATA:    if (tx_tick && tx_bit == 3'd7) tx_nx = tx_pe ? PARITY : STOP;
      PARITY:  if (tx_tick) tx_nx = STOP;
      STOP:    if (tx_tick) tx_nx = IDLE;
      default: tx_nx = IDLE;
    endcase
    if (tx_load) tx_nx = START;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_div <= ONE;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_pe <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= (tx_st == IDLE || tx_load || tx_tick) ? '0 : tx_cnt + ONE;
      if (tx_load) begin
        tx_div <= div_eff;
        tx_pe <= ctrl[1];
        tx_sh <= tx_dout;
        tx_par <= ^tx_dout ^ ctrl[2];
        tx_bit <= '0;
      end else if (tx_st == DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
    end
  assign uart_tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;

  // the start bit is rechecked after half a bit, every later bit one full bit apart
  assign rx_lim = rx_st == START ? (rx_div >> 1) - DIV_WIDTH'(rx_div > ONE) : rx_div - ONE;
  assign rx_tick = rx_cnt == rx_lim;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    if (ctrl[0] && rx_q && !rx_s) rx_nx = START;
      START:   if (rx_tick) rx_nx = rx_s ? IDLE : DATA;
      DATA:    if (rx_tick && rx_bit == 3'd7) rx_nx = rx_pe ? PARITY : STOP;
      PARITY:  if (rx_tick) rx_nx = STOP;
      STOP:    if (rx_tick) rx_nx = IDLE;
      default: rx_nx = IDLE;
    endcase
  end
  assign rx_push = rx_st == STOP & rx_tick & rx_s;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      {rx_q, rx_s, rx_m} <= 3'b111;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_div <= ONE;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_pe <= 1'b0;
      rx_odd <= 1'b0;
    end else begin
      {rx_q, rx_s, rx_m} <= {rx_s, rx_m, uart_rx};
      rx_st <= rx_nx;
      rx_cnt <= (rx_st == IDLE || rx_tick) ? '0 : rx_cnt + ONE;
      if (rx_st == IDLE) begin
        rx_div <= div_eff;
        rx_pe <= ctrl[1];
        rx_odd <= ctrl[2];
        rx_bit <= '0;
      end
      if (rx_st == DATA && rx_tick) begin
        rx_sh <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end

  assign err_set = {rx_st == STOP & rx_tick & ~rx_s,
                    rx_st == PARITY & rx_tick & (rx_s != (^rx_sh ^ rx_odd)),
                    rx_push & rx_full & ~rx_pop};
  assign err_clr = wr_en & a_stat ? PWDATA[6:4] : 3'b000;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      ctrl <= '0;
      baud <= DIV_WIDTH'(16);
      err <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_en && a_ctrl) ctrl <= PWDATA[4:0];
      if (wr_en && a_baud) baud <= PWDATA[DIV_WIDTH-1:0];
      err <= (err & ~err_clr) | err_set;
      irq <= (ctrl[3] & ~rx_empty) | (ctrl[4] & tx_empty);
    end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb_apb_uart_fifo: directed and randomized checks of the APB UART against a frame/queue model.
module tb_apb_uart_fifo;
  localparam int DEPTH = 8;
  logic PCLK = 1'b0, PRESETn, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, uart_tx, uart_rx, irq;
  logic [7:0] PADDR;
  logic [31:0] PWDATA, PRDATA, d;
  logic e, rx_inj, loop;
  int checks = 0, errors = 0;
  logic [7:0] rxq[$], txq[$];
  bit m_ovr, m_perr, m_ferr;

  always #5 PCLK = ~PCLK;
  assign uart_rx = loop ? uart_tx : rx_inj;

  apb_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq));

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] wd);
    @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = wd;
    @(negedge PCLK); PENABLE = 1; #1 d = PRDATA; e = PSLVERR;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic peek(input logic [7:0] a);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    #1 d = PRDATA; PSEL = 0;
  endtask

  function automatic logic [10:0] mframe(input logic [7:0] b, input bit pe, input bit odd);
    mframe = '0;
    mframe[8:1] = b;
    if (pe) begin mframe[9] = ^b ^ odd; mframe[10] = 1'b1; end
    else mframe[9] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    return {24'h0, 1'b0, m_ferr, m_perr, m_ovr, rxq.size() == 0, rxq.size() == DEPTH, 2'b10};
  endfunction

  // capture one frame from uart_tx, requiring every bit to hold steady for exactly div cycles
  task automatic get_frame(input int div, input int nbits, output logic [10:0] fr, output bit ok, output int waited);
    fr = '0; ok = 1; waited = 0;
    @(negedge PCLK);
    while (uart_tx !== 1'b0 && waited < 5000) begin @(negedge PCLK); waited++; end
    if (waited >= 5000) begin ok = 0; return; end
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < div; j++) begin
        if (k != 0 || j != 0) @(negedge PCLK);
        if (j == 0) fr[k] = uart_tx;
        else if (uart_tx !== fr[k]) ok = 0;
      end
  endtask

  task automatic inject(input int div, input logic [7:0] b, input bit pe, input bit odd, input bit par, input bit stp);
    logic [10:0] v;
    int n;
    v = '0; v[8:1] = b; n = pe ? 11 : 10;
    if (pe) begin v[9] = par; v[10] = stp; end else v[9] = stp;
    for (int k = 0; k < n; k++) begin
      @(negedge PCLK); rx_inj = v[k];
      repeat (div - 1) @(negedge PCLK);
    end
    @(negedge PCLK); rx_inj = 1'b1;
    repeat (div + 2) @(negedge PCLK);
    if (pe && par != (^b ^ odd)) m_perr = 1;
    if (!stp) m_ferr = 1;
    else if (rxq.size() == DEPTH) m_ovr = 1;
    else rxq.push_back(b);
  endtask

  task automatic drain(input string tag);
    while (rxq.size() != 0) begin
      apb(0, 8'h0C, 0);
      chk(tag, d, {24'h0, rxq.pop_front()});
    end
  endtask

  logic [10:0] fr;
  bit ok;
  int waited, lows, bd, dv;
  logic [7:0] b;
  bit pe, odd, par, stp;

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; rx_inj = 1; loop = 0; PRESETn = 0;
    repeat (3) @(negedge PCLK);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_pready", PREADY, 1);
    PRESETn = 1;
    apb(0, 8'h10, 0); chk("rst_status", d, 32'h0A);
    apb(0, 8'h00, 0); chk("rst_ctrl", d, 0);
    apb(0, 8'h04, 0); chk("rst_baud", d, 16);
    apb(0, 8'h40, 0); chk("unmapped_rd", d, 0); chk("unmapped_err", e, 1);

    // basic 0x55 frame at divisor 16 with exact bit timing and busy window
    apb(1, 8'h00, 1);
    apb(1, 8'h08, 32'h55);
    get_frame(16, 10, fr, ok, waited);
    chk("f55_ok", ok, 1);
    chk("f55_frame", fr, mframe(8'h55, 0, 0));
    peek(8'h10); chk("f55_busy_end", d, 32'h8A);
    @(negedge PCLK); peek(8'h10); chk("f55_idle_after", d, 32'h0A);

    // directed odd parity then randomized divisor/parity/data
    apb(1, 8'h04, 4); apb(1, 8'h00, 32'h07); apb(1, 8'h08, 32'h07);
    get_frame(4, 11, fr, ok, waited);
    chk("par07_ok", ok, 1); chk("par07_bit", fr[9], 0); chk("par07_frame", fr, mframe(8'h07, 1, 1));
    for (int i = 0; i < 6; i++) begin
      bd = $urandom_range(0, 6); pe = 1'($urandom); odd = 1'($urandom); b = 8'($urandom);
      dv = bd == 0 ? 1 : bd;
      apb(1, 8'h04, bd); apb(1, 8'h00, {29'h0, odd, pe, 1'b1}); apb(1, 8'h08, b);
      get_frame(dv, pe ? 11 : 10, fr, ok, waited);
      chk("rnd_tx_ok", ok, 1);
      chk("rnd_tx_frame", fr, mframe(b, pe, odd));
    end

    // loopback at divisor 8
    loop = 1; pe = 1'($urandom); odd = 1'($urandom);
    apb(1, 8'h04, 8); apb(1, 8'h00, {29'h0, odd, pe, 1'b1});
    for (int i = 0; i < 3; i++) begin
      b = i == 0 ? 8'hA5 : i == 1 ? 8'h3C : 8'($urandom);
      apb(1, 8'h08, b); rxq.push_back(b);
    end
    repeat (320) @(negedge PCLK);
    drain("loop_rx");
    apb(0, 8'h0C, 0); chk("loop_empty_rd", d, 0);
    peek(8'h10); chk("loop_status", d, exp_status());
    loop = 0;

    // fill TX with EN=0, ninth write rejected, then exactly 8 back-to-back frames
    apb(1, 8'h00, 0); apb(1, 8'h04, 4);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      apb(1, 8'h08, b);
      chk("txfill_err", e, i == 8);
      if (i < 8) txq.push_back(b);
    end
    peek(8'h10); chk("txfull_status", d, 32'h09);
    apb(1, 8'h00, 1);
    for (int i = 0; i < 8; i++) begin
      get_frame(4, 10, fr, ok, waited);
      chk("txq_ok", ok, 1);
      chk("txq_frame", fr, mframe(txq.pop_front(), 0, 0));
      if (i > 0) chk("txq_b2b", waited, 0);
    end
    lows = 0;
    repeat (100) begin @(negedge PCLK); if (uart_tx !== 1'b1) lows++; end
    chk("txq_no_9th", lows, 0);
    peek(8'h10); chk("txq_status", d, 32'h0A);

    // parity error on receive, W1C clear
    apb(1, 8'h04, 8); apb(1, 8'h00, 32'h07);
    inject(8, 8'h07, 1, 1, 1, 1);
    peek(8'h10); chk("perr_status", d, exp_status());
    chk("perr_status_abs", d, 32'h22);
    drain("perr_rx");
    apb(1, 8'h10, 32'h20); m_perr = 0;
    peek(8'h10); chk("perr_cleared", d, 32'h0A);

    // overrun, false start, frame error
    apb(1, 8'h00, 1);
    for (int i = 1; i <= 9; i++) inject(8, 8'(i), 0, 0, 0, 1);
    peek(8'h10); chk("ovr_status", d, exp_status()); chk("ovr_status_abs", d, 32'h16);
    drain("ovr_rx");
    peek(8'h10); chk("ovr_after_drain", d, 32'h1A);
    apb(1, 8'h10, 32'h10); m_ovr = 0;
    peek(8'h10); chk("ovr_cleared", d, 32'h0A);
    @(negedge PCLK); rx_inj = 0; repeat (2) @(negedge PCLK); rx_inj = 1;
    repeat (40) @(negedge PCLK);
    peek(8'h10); chk("false_start", d, 32'h0A);
    inject(8, 8'h5A, 0, 0, 0, 0);
    peek(8'h10); chk("ferr_status", d, exp_status()); chk("ferr_status_abs", d, 32'h4A);
    apb(1, 8'h10, 32'h40); m_ferr = 0;

    // random receive frames with random configuration and faults
    for (int i = 0; i < 5; i++) begin
      bd = $urandom_range(4, 10); pe = 1'($urandom); odd = 1'($urandom); b = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~(^b ^ odd) : (^b ^ odd);
      stp = $urandom_range(0, 3) != 0;
      apb(1, 8'h04, bd); apb(1, 8'h00, {29'h0, odd, pe, 1'b1});
      inject(bd, b, pe, odd, par, stp);
      peek(8'h10); chk("rnd_rx_status", d, exp_status());
    end
    drain("rnd_rx_data");
    apb(1, 8'h10, 32'h70); m_ovr = 0; m_perr = 0; m_ferr = 0;
    peek(8'h10); chk("rnd_rx_final", d, exp_status());

    // interrupts
    apb(1, 8'h04, 8); apb(1, 8'h00, 32'h09);
    repeat (2) @(negedge PCLK); chk("irq_rx_empty", irq, 0);
    inject(8, 8'hE7, 0, 0, 0, 1);
    chk("irq_rx_full", irq, 1);
    drain("irq_rx");
    repeat (2) @(negedge PCLK); chk("irq_rx_drained", irq, 0);
    apb(1, 8'h00, 32'h11);
    repeat (2) @(negedge PCLK); chk("irq_tx_empty", irq, 1);

    // reset in the middle of a frame
    apb(1, 8'h04, 16); apb(1, 8'h08, 0);
    repeat (26) @(negedge PCLK);
    chk("pre_rst_tx_low", uart_tx, 0);
    chk("pre_rst_irq", irq, 1);
    #2 PRESETn = 0;
    #1 chk("midrst_tx", uart_tx, 1);
    chk("midrst_irq", irq, 0);
    peek(8'h10); chk("midrst_status", d, 32'h0A);
    @(negedge PCLK); PRESETn = 1;
    apb(0, 8'h04, 0); chk("post_rst_baud", d, 16);
    apb(1, 8'h00, 1); apb(1, 8'h08, 32'hC3);
    get_frame(16, 10, fr, ok, waited);
    chk("post_rst_ok", ok, 1);
    chk("post_rst_frame", fr, mframe(8'hC3, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_uart_fifo.md
Name:
apb_uart_fifo

Overview:
APB-attached UART with parametrised TX/RX FIFOs, programmable baud divisor, optional parity, sticky error status and a level interrupt. It succeeds the single-byte APB UART: registers at offsets 0x00/0x04/0x08 keep their meaning, and RX data, status and interrupt enables are added. It sits on the peripheral APB bus as a slave with always-ready, zero-wait-state timing.

Parameters:
FIFO_DEPTH, 8, entries per TX and per RX FIFO; power of two, minimum 2.
DIV_WIDTH, 16, width of the baud divisor (PCLK cycles per bit).

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESETn  in  1  asynchronous active-low reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1=write, 0=read.
PADDR  in  8  byte address.
PWDATA  in  32  write data.
PRDATA  out  32  read data; combinational from PADDR when PSEL=1, else 0.
PREADY  out  1  tied 1.
PSLVERR  out  1  error response, valid in access phase.
uart_tx  out  1  serial out; idle high.
uart_rx  in  1  serial in; asynchronous, idle high.
irq  out  1  level interrupt.

Behaviour:
- Access commits only when PSEL&PENABLE=1 (access phase); setup phase has no side effects.
- 0x00 CTRL (RW, reset 0): b0 EN, b1 PAR_EN, b2 PAR_ODD, b3 RX_IE, b4 TX_IE.
- 0x04 BAUD (RW, reset 16): divisor. A value of 0 behaves as 1.
- 0x08 TXDATA (W): pushes PWDATA[7:0]. If TX FIFO is full, the write is dropped and PSLVERR=1. Reads return 0.
- 0x0C RXDATA (R): returns {24'b0, head} and pops. If RX FIFO is empty, returns 0, no pop. Writes are ignored.
- 0x10 STATUS: b0 TX_FULL, b1 TX_EMPTY, b2 RX_FULL, b3 RX_EMPTY, b4 OVERRUN, b5 PAR_ERR, b6 FRAME_ERR, b7 TX_BUSY. Bits 4-6 are sticky and write-1-to-clear. A set event in the same cycle as a clear wins.
- Unmapped address: PSLVERR=1, write ignored, read 0.
- Reset values: uart_tx=1, PRDATA=0, PSLVERR=0, irq=0, FIFOs empty, STATUS=0x0A, both FSMs in IDLE.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Leaves IDLE when EN=1 and TX FIFO is non-empty. The byte is popped on that transition.
  - Each state lasts BAUD cycles. DATA sends 8 bits LSB first. PARITY is present only if PAR_EN.
  - Parity bit = XOR of data bits, inverted when PAR_ODD. STOP is 1 bit high.
  - After STOP, returns to IDLE; back-to-back frames have no extra idle cycle.
  - Clearing EN mid-frame finishes the current frame and starts no new one.
  - CTRL/BAUD changes mid-frame take effect at the next frame.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - RX FSM (IDLE, START, DATA, PARITY, STOP) leaves IDLE on a synchronised high-to-low transition while EN=1.
  - At BAUD/2 the start bit is rechecked. If it is high, this is a false start: return to IDLE with no status change.
  - Thereafter each bit is sampled every BAUD cycles (mid-bit).
  - Parity mismatch sets PAR_ERR; the byte is still pushed.
  - Stop bit sampled low sets FRAME_ERR; the byte is discarded.
  - Push when RX FIFO is full sets OVERRUN and drops the new byte; existing contents are kept.
  - Pop and push in the same cycle with the FIFO full: both succeed, no OVERRUN.
- FIFOs: circular, pointer wrap at FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1 so full and empty are distinguishable.
- irq = (RX_IE & ~RX_EMPTY) | (TX_IE & TX_EMPTY), from registered state, no glitches.
- PRESETn asserted mid-frame: immediate return to reset values; uart_tx goes high asynchronously.

Test Plan:
- CTRL=1, BAUD=16, TXDATA=0x55 -> uart_tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, high stop; frame 160 cycles; TX_BUSY=1 during, TX_EMPTY=1 after.
- Loopback uart_tx->uart_rx, BAUD=8, write 0xA5 then 0x3C -> RXDATA reads 0xA5, then 0x3C, then 0 with STATUS.RX_EMPTY=1; no error bits set.
- EN=0, nine TXDATA writes -> writes 1-8 have PSLVERR=0, the 9th has PSLVERR=1, STATUS.TX_FULL=1; set EN -> exactly 8 frames are sent.
- PAR_EN=1, PAR_ODD=1, TXDATA=0x07 -> parity bit 0. Inject RX frame 0x07 with parity 1 -> PAR_ERR=1, RXDATA=0x07; write 0x20 to STATUS -> PAR_ERR=0.
- Inject 9 RX frames 0x01..0x09 without reading -> OVERRUN=1, reads return 0x01..0x08. Frame with stop bit low -> FRAME_ERR=1, RX_EMPTY stays 1. RX_IE=1 -> irq=1 while RX non-empty.
- PRESETn low during the DATA state of a TX frame -> uart_tx=1 immediately, STATUS=0x0A, irq=0; after release, a new TXDATA write produces a clean frame.
